// File: rtl/maxi_core32.sv
// maxi_core32: 32-bit multicycle load/store CPU with a single word-addressed
// big-endian memory bus (fetch / execute / optional memory cycle per instruction).
module maxi_core32 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [29:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic [3:0]  data_strobes,
  output logic        read,
  output logic        write,
  output logic        bus_error
);

  localparam logic [5:0] OP_NOP    = 6'h00;
  localparam logic [5:0] OP_HALT   = 6'h01;
  localparam logic [5:0] OP_LOADI  = 6'h02;
  localparam logic [5:0] OP_LOAD   = 6'h03;
  localparam logic [5:0] OP_STORE  = 6'h04;
  localparam logic [5:0] OP_LOADB  = 6'h05;
  localparam logic [5:0] OP_STOREB = 6'h06;
  localparam logic [5:0] OP_JUMP   = 6'h08;
  localparam logic [5:0] OP_CALL   = 6'h09;
  localparam logic [5:0] OP_BEQZ   = 6'h0A;
  localparam logic [5:0] OP_BNEZ   = 6'h0B;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_EXECUTE = 3'd1,
    S_MEMORY  = 3'd2,
    S_HALTED  = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [31:0]       r_pc;
  logic [31:0]       r_ir;
  logic [31:0]       r_ea;
  logic [15:0][31:0] r_regs;
  logic              r_bus_error;

  logic [5:0]  w_op;
  logic [3:0]  w_rd;
  logic [3:0]  w_rs;
  logic [3:0]  w_rt;
  logic [31:0] w_imm;
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  logic [31:0] w_rd_val;
  logic [31:0] w_operand_b;
  logic [31:0] w_ea;
  logic [31:0] w_br_target;
  logic [31:0] w_alu_res;
  logic        w_br_taken;
  logic        w_is_byte;
  logic        w_is_load;
  logic [31:0] w_pc_next;
  logic        w_reg_we;
  logic [31:0] w_reg_wdata;
  logic        w_fault;

  // ALU: ADD, SUB, AND, OR, XOR, SHL, SHR, ASR on the low 5 bits of b.
  function automatic logic [31:0] alu(input logic [2:0] fn, input logic [31:0] a,
                                      input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (fn)
      3'd0:    alu = a + b;
      3'd1:    alu = a - b;
      3'd2:    alu = a & b;
      3'd3:    alu = a | b;
      3'd4:    alu = a ^ b;
      3'd5:    alu = a << b[4:0];
      3'd6:    alu = a >> b[4:0];
      default: alu = sa >>> b[4:0];
    endcase
  endfunction

  // Byte offset 0 is the most significant lane (big-endian).
  function automatic logic [7:0] lane_sel(input logic [31:0] word, input logic [1:0] off);
    case (off)
      2'd0:    lane_sel = word[31:24];
      2'd1:    lane_sel = word[23:16];
      2'd2:    lane_sel = word[15:8];
      default: lane_sel = word[7:0];
    endcase
  endfunction

  assign w_op        = r_ir[31:26];
  assign w_rd        = r_ir[25:22];
  assign w_rs        = r_ir[21:18];
  assign w_rt        = r_ir[17:14];
  assign w_imm       = {{14{r_ir[17]}}, r_ir[17:0]};
  assign w_rs_val    = r_regs[w_rs];
  assign w_rt_val    = r_regs[w_rt];
  assign w_rd_val    = r_regs[w_rd];
  assign w_operand_b = w_op[3] ? w_imm : w_rt_val;
  assign w_ea        = w_rs_val + w_imm;
  assign w_br_target = r_pc + w_imm;
  assign w_alu_res   = alu(w_op[2:0], w_rs_val, w_operand_b);
  assign w_br_taken  = (w_op == OP_BEQZ) ? (w_rs_val == 32'h0) : (w_rs_val != 32'h0);
  assign w_is_byte   = (w_op == OP_LOADB) || (w_op == OP_STOREB);
  assign w_is_load   = (w_op == OP_LOAD) || (w_op == OP_LOADB);
  assign bus_error   = r_bus_error;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_pc_next    = r_pc;
    w_reg_we     = 1'b0;
    w_reg_wdata  = 32'h0;
    w_fault      = 1'b0;
    address      = 30'h0;
    data_out     = 32'h0;
    data_strobes = 4'h0;
    read         = 1'b0;
    write        = 1'b0;
    case (r_state)
      S_FETCH: begin
        address      = r_pc[31:2];
        read         = 1'b1;
        data_strobes = 4'hF;
        w_next_state = S_EXECUTE;
      end
      S_EXECUTE: begin
        w_next_state = S_FETCH;
        case (w_op)
          OP_NOP: ;
          OP_HALT: w_next_state = S_HALTED;
          OP_LOADI: begin
            w_reg_we    = 1'b1;
            w_reg_wdata = w_imm;
          end
          OP_LOAD, OP_STORE: begin
            if (w_ea[1:0] != 2'b00) w_fault = 1'b1;
            else                    w_next_state = S_MEMORY;
          end
          OP_LOADB, OP_STOREB: w_next_state = S_MEMORY;
          OP_JUMP: begin
            if (w_ea[1:0] != 2'b00) w_fault = 1'b1;
            else                    w_pc_next = w_ea;
          end
          OP_CALL: begin
            if (w_ea[1:0] != 2'b00) begin
              w_fault = 1'b1;
            end else begin
              w_reg_we    = 1'b1;
              w_reg_wdata = r_pc;
              w_pc_next   = w_ea;
            end
          end
          OP_BEQZ, OP_BNEZ: begin
            if (w_br_taken) begin
              if (w_br_target[1:0] != 2'b00) w_fault = 1'b1;
              else                           w_pc_next = w_br_target;
            end
          end
          default: begin
            if (w_op[5:4] == 2'b01) begin
              w_reg_we    = 1'b1;
              w_reg_wdata = w_alu_res;
            end else begin
              w_fault = 1'b1;
            end
          end
        endcase
        // A faulting instruction leaves PC and registers untouched.
        if (w_fault) begin
          w_next_state = S_FAULT;
          w_reg_we     = 1'b0;
          w_pc_next    = r_pc;
        end
      end
      S_MEMORY: begin
        address      = r_ea[31:2];
        data_strobes = w_is_byte ? (4'b1000 >> r_ea[1:0]) : 4'hF;
        if (w_is_load) begin
          read        = 1'b1;
          w_reg_we    = 1'b1;
          w_reg_wdata = w_is_byte ? {24'h0, lane_sel(data_in, r_ea[1:0])} : data_in;
        end else begin
          write    = 1'b1;
          data_out = w_is_byte ? {4{w_rd_val[7:0]}} : w_rd_val;
        end
        w_next_state = S_FETCH;
      end
      S_HALTED, S_FAULT: ;
      default: w_next_state = S_FAULT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_ir        <= 32'h0;
      r_ea        <= 32'h0;
      r_regs      <= '0;
      r_bus_error <= 1'b0;
    end else begin
      if (r_state == S_FETCH) begin
        r_ir <= data_in;
        r_pc <= r_pc + 32'd4;
      end
      if (r_state == S_EXECUTE) begin
        r_pc <= w_pc_next;
        r_ea <= w_ea;
      end
      if (w_reg_we && (w_rd != 4'd0)) r_regs[w_rd] <= w_reg_wdata;
      if (w_fault) r_bus_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_maxi_core32.sv
// Bench for maxi_core32: a bus memory plus an instruction-level reference model
// that predicts every bus cycle of directed and random programs.
module tb_maxi_core32;

  logic        clock = 1'b0;
  logic        reset;
  logic [29:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [3:0]  data_strobes;
  logic        read;
  logic        write;
  logic        bus_error;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic [31:0] ref_regs[16];
  logic [31:0] ref_pc;
  int          ref_mode;   // 0 running, 1 halted, 2 faulted
  int          checks = 0;
  int          errors = 0;

  maxi_core32 #(.RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .address(address), .data_in(data_in),
    .data_out(data_out), .data_strobes(data_strobes), .read(read),
    .write(write), .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  assign data_in = (read === 1'b1 && address < 30'd256) ? mem[address[7:0]] : 32'h0;

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs, input logic [17:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs, input logic [3:0] rt);
    return {op, rd, rs, rt, 14'h0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic rd, input logic wr, input logic [29:0] a,
                     input logic [3:0] s, input logic [31:0] d, input logic be);
    chk({tag, ".read"},    {31'h0, read},         {31'h0, rd});
    chk({tag, ".write"},   {31'h0, write},        {31'h0, wr});
    chk({tag, ".strobes"}, {28'h0, data_strobes}, {28'h0, s});
    chk({tag, ".dout"},    data_out,              d);
    chk({tag, ".berr"},    {31'h0, bus_error},    {31'h0, be});
    if (rd || wr) chk({tag, ".addr"}, {2'b0, address}, {2'b0, a});
  endtask

  // Apply any write of the current cycle to the bus memory, then advance.
  task automatic tick();
    if (write === 1'b1 && address < 30'd256)
      for (int l = 0; l < 4; l++)
        if (data_strobes[l]) mem[address[7:0]][8*l +: 8] = data_out[8*l +: 8];
    @(negedge clock);
  endtask

  task automatic put(input logic [9:0] a, input logic [31:0] w);
    mem[a[9:2]]     = w;
    ref_mem[a[9:2]] = w;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
  endtask

  task automatic wreg(input logic [3:0] r, input logic [31:0] v);
    if (r != 4'd0) ref_regs[r] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    cyc("reset", 1'b1, 1'b0, 30'd0, 4'hF, 32'h0, 1'b0);
    reset    = 1'b0;
    ref_pc   = 32'h0;
    ref_mode = 0;
    for (int i = 0; i < 16; i++) ref_regs[i] = 32'h0;
  endtask

  // Executes one instruction in the model, checking each bus cycle it implies.
  task automatic ref_step();
    logic [31:0] ins, imm, a, b, ea, tgt, res, w;
    logic [5:0]  op;
    logic [3:0]  rd, rs, rt, strb;
    logic [7:0]  bv;
    logic        take;
    if (ref_mode == 1) begin
      cyc("halted", 1'b0, 1'b0, 30'd0, 4'h0, 32'h0, 1'b0); tick(); return;
    end
    if (ref_mode == 2) begin
      cyc("fault", 1'b0, 1'b0, 30'd0, 4'h0, 32'h0, 1'b1); tick(); return;
    end
    ins = ref_mem[ref_pc[9:2]];
    cyc("fetch", 1'b1, 1'b0, ref_pc[31:2], 4'hF, 32'h0, 1'b0); tick();
    ref_pc = ref_pc + 32'd4;
    cyc("exec", 1'b0, 1'b0, 30'd0, 4'h0, 32'h0, 1'b0); tick();
    op  = ins[31:26];
    rd  = ins[25:22];
    rs  = ins[21:18];
    rt  = ins[17:14];
    imm = {{14{ins[17]}}, ins[17:0]};
    a   = ref_regs[rs];
    ea  = a + imm;
    strb = 4'b1000 >> ea[1:0];
    case (op)
      6'h00: ;
      6'h01: ref_mode = 1;
      6'h02: wreg(rd, imm);
      6'h03: if (ea[1:0] != 0) ref_mode = 2; else begin
        cyc("load", 1'b1, 1'b0, ea[31:2], 4'hF, 32'h0, 1'b0);
        w = ref_mem[ea[9:2]]; tick(); wreg(rd, w);
      end
      6'h04: if (ea[1:0] != 0) ref_mode = 2; else begin
        cyc("store", 1'b0, 1'b1, ea[31:2], 4'hF, ref_regs[rd], 1'b0);
        ref_mem[ea[9:2]] = ref_regs[rd]; tick();
      end
      6'h05: begin
        cyc("loadb", 1'b1, 1'b0, ea[31:2], strb, 32'h0, 1'b0);
        w  = ref_mem[ea[9:2]];
        bv = 8'(w >> (24 - 8 * ea[1:0]));
        tick(); wreg(rd, {24'h0, bv});
      end
      6'h06: begin
        cyc("storeb", 1'b0, 1'b1, ea[31:2], strb, {4{ref_regs[rd][7:0]}}, 1'b0);
        w = ref_mem[ea[9:2]];
        w[(24 - 8 * ea[1:0]) +: 8] = ref_regs[rd][7:0];
        ref_mem[ea[9:2]] = w; tick();
      end
      6'h08: if (ea[1:0] != 0) ref_mode = 2; else ref_pc = ea;
      6'h09: if (ea[1:0] != 0) ref_mode = 2; else begin wreg(rd, ref_pc); ref_pc = ea; end
      6'h0A, 6'h0B: begin
        take = (op == 6'h0A) ? (a == 0) : (a != 0);
        tgt  = ref_pc + imm;
        if (take) begin
          if (tgt[1:0] != 0) ref_mode = 2; else ref_pc = tgt;
        end
      end
      default: begin
        if (op >= 6'h10 && op <= 6'h1F) begin
          b = (op >= 6'h18) ? imm : ref_regs[rt];
          case (op[2:0])
            3'd0: res = a + b;
            3'd1: res = a - b;
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: res = a << b[4:0];
            3'd6: res = a >> b[4:0];
            default: res = $signed(a) >>> b[4:0];
          endcase
          wreg(rd, res);
        end else begin
          ref_mode = 2;
        end
      end
    endcase
  endtask

  task automatic run(input int max_steps);
    for (int s = 0; s < max_steps && ref_mode == 0; s++) ref_step();
    ref_step();
    ref_step();
  endtask

  logic [31:0] bad_prog [4];
  logic [9:0]  pa;
  logic [5:0]  rop;
  logic [3:0]  rrd, rrs, rrt;
  logic [17:0] rimm;

  initial begin
    reset = 1'b1;

    // All-zero memory: NOPs, one fetch every two clocks.
    clear_mem();
    do_reset();
    for (int i = 0; i < 8; i++) ref_step();
    chk("nop_addr", {2'b0, address}, 32'd8);

    // LOADI / STORE word / LOADB big-endian lane.
    clear_mem();
    put(10'h000, enc_i(6'h02, 4'd1, 4'd0, 18'h01234));
    put(10'h004, enc_i(6'h02, 4'd2, 4'd0, 18'h00100));
    put(10'h008, enc_i(6'h04, 4'd1, 4'd2, 18'd4));
    put(10'h00C, enc_i(6'h05, 4'd3, 4'd2, 18'd1));
    put(10'h010, enc_i(6'h04, 4'd3, 4'd2, 18'd8));
    put(10'h014, enc_i(6'h01, 4'd0, 4'd0, 18'd0));
    put(10'h100, 32'hAABBCCDD);
    do_reset();
    run(20);
    chk("store_word", mem[65], 32'h00001234);
    chk("loadb_byte", mem[66], 32'h000000BB);

    // ALU: ADDI wrap, SHR vs ASR, register SUB.
    clear_mem();
    put(10'h000, enc_i(6'h02, 4'd1, 4'd0, 18'h3FFFF));
    put(10'h004, enc_i(6'h18, 4'd1, 4'd1, 18'd2));
    put(10'h008, enc_i(6'h02, 4'd4, 4'd0, 18'd1));
    put(10'h00C, enc_i(6'h1D, 4'd4, 4'd4, 18'd31));
    put(10'h010, enc_i(6'h1E, 4'd5, 4'd4, 18'd4));
    put(10'h014, enc_i(6'h1F, 4'd6, 4'd4, 18'd4));
    put(10'h018, enc_i(6'h04, 4'd1, 4'd0, 18'h110));
    put(10'h01C, enc_i(6'h04, 4'd5, 4'd0, 18'h114));
    put(10'h020, enc_i(6'h04, 4'd6, 4'd0, 18'h118));
    put(10'h024, enc_r(6'h11, 4'd7, 4'd5, 4'd6));
    put(10'h028, enc_i(6'h04, 4'd7, 4'd0, 18'h11C));
    put(10'h02C, enc_i(6'h01, 4'd0, 4'd0, 18'd0));
    do_reset();
    run(30);
    chk("addi_wrap", mem[68], 32'h00000001);
    chk("shr",       mem[69], 32'h08000000);
    chk("asr",       mem[70], 32'hF8000000);
    chk("sub_reg",   mem[71], 32'h10000000);

    // BNEZ backwards loop, CALL, JUMP through the return register.
    clear_mem();
    put(10'h000, enc_i(6'h02, 4'd1, 4'd0, 18'd2));
    put(10'h004, enc_i(6'h18, 4'd1, 4'd1, 18'h3FFFF));
    put(10'h008, enc_i(6'h0B, 4'd0, 4'd1, 18'h3FFF8));
    put(10'h00C, enc_i(6'h09, 4'd7, 4'd0, 18'h20));
    put(10'h010, enc_i(6'h01, 4'd0, 4'd0, 18'd0));
    put(10'h020, enc_i(6'h04, 4'd7, 4'd0, 18'h120));
    put(10'h024, enc_i(6'h08, 4'd0, 4'd7, 18'd0));
    do_reset();
    run(30);
    chk("call_link", mem[72], 32'h00000010);
    chk("halt_read", {31'h0, read}, 32'h0);

    // Misaligned word load faults; reset recovers and refetches from 0.
    clear_mem();
    put(10'h000, enc_i(6'h02, 4'd2, 4'd0, 18'h100));
    put(10'h004, enc_i(6'h03, 4'd3, 4'd2, 18'd2));
    do_reset();
    run(10);
    chk("fault_berr",  {31'h0, bus_error}, 32'h1);
    chk("fault_read",  {31'h0, read},      32'h0);
    chk("fault_write", {31'h0, write},     32'h0);
    do_reset();
    ref_step();

    // Other fault sources: undefined opcodes, misaligned branch / jump targets.
    bad_prog[0] = enc_i(6'h07, 4'd0, 4'd0, 18'd0);
    bad_prog[1] = enc_i(6'h0A, 4'd0, 4'd0, 18'd2);
    bad_prog[2] = enc_i(6'h08, 4'd0, 4'd0, 18'h21);
    bad_prog[3] = enc_i(6'h20, 4'd1, 4'd0, 18'd0);
    for (int k = 0; k < 4; k++) begin
      clear_mem();
      put(10'h000, bad_prog[k]);
      do_reset();
      run(4);
      chk($sformatf("bad%0d_berr", k), {31'h0, bus_error}, 32'h1);
    end

    // Random programs of ALU, LOADI and byte/word memory ops, then dump r1..r15.
    for (int t = 0; t < 3; t++) begin
      clear_mem();
      for (int w = 192; w < 256; w++) begin
        pa = 10'(w * 4);
        put(pa, $urandom);
      end
      pa = 10'h0;
      for (int i = 0; i < 24; i++) begin
        rrd  = 4'($urandom_range(1, 15));
        rrs  = 4'($urandom_range(0, 15));
        rrt  = 4'($urandom_range(0, 15));
        rimm = 18'($urandom);
        case ($urandom_range(0, 5))
          0: put(pa, enc_i(6'h02, rrd, 4'd0, rimm));
          1: begin rop = 6'h10 + 6'($urandom_range(0, 7)); put(pa, enc_r(rop, rrd, rrs, rrt)); end
          2: begin rop = 6'h18 + 6'($urandom_range(0, 7)); put(pa, enc_i(rop, rrd, rrs, rimm)); end
          3: put(pa, enc_i(6'h05, rrd, 4'd0, 18'(12'h300 + $urandom_range(0, 255))));
          4: put(pa, enc_i(6'h03, rrd, 4'd0, 18'(12'h300 + 4 * $urandom_range(0, 63))));
          default: put(pa, enc_i(6'h06, rrd, 4'd0, 18'(12'h2C0 + $urandom_range(0, 63))));
        endcase
        pa = pa + 10'd4;
      end
      for (int r = 1; r < 16; r++) begin
        put(pa, enc_i(6'h04, 4'(r), 4'd0, 18'(12'h200 + 4 * r)));
        pa = pa + 10'd4;
      end
      put(pa, enc_i(6'h01, 4'd0, 4'd0, 18'd0));
      do_reset();
      run(80);
      chk($sformatf("rand%0d_halted", t), {31'h0, bus_error}, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/maxi_core32.md
Name: maxi_core32

Overview:
- Minimal 32-bit multicycle load/store CPU core with one 32-bit word-addressed memory bus, byte strobes and separate read/write qualifiers.
- Top-level processor block. Memory/peripherals sit outside and return read data combinationally on data_in in the same cycle.
- Fetches big-endian 32-bit instructions from address 0 after reset.
- Raises bus_error and stops on a fault.

Parameters:
- RESET_PC, 32'h00000000, byte address of the first fetch after reset (must be word aligned).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- address  out  30  word address [31:2] of the current bus cycle.
- data_in  in  32  read data, sampled on the rising edge that ends a read cycle.
- data_out  out  32  write data; 0 when write=0.
- data_strobes  out  4  byte lanes; bit3=data[31:24]=byte offset 0 (big-endian), bit0=offset 3.
- read  out  1  read cycle this clock.
- write  out  1  write cycle this clock.
- bus_error  out  1  sticky fault flag.

Behaviour:
- Architectural state: PC (32 bit); r0..r15 (32 bit each, r0 reads 0 and writes to it are ignored); IR (32 bit).
- States: FETCH, EXECUTE, MEMORY, HALTED, FAULT.
- Reset (at the clock edge): PC=RESET_PC, all registers 0, state=FETCH, bus_error=0.
- Outputs are decoded from state, so the first cycle after reset shows address=0, read=1, data_strobes=1111.
- FETCH: address=PC[31:2], read=1, strobes=1111, write=0. At the edge: IR<=data_in, PC<=PC+4, go to EXECUTE.
- EXECUTE: read=write=0, strobes=0000. Execute IR, then go to FETCH, MEMORY, HALTED or FAULT.
- Instruction format: op=IR[31:26], rd=IR[25:22], rs=IR[21:18], rt=IR[17:14], imm=sign-extended IR[17:0].
- op 0x00 NOP. An all-zero bus therefore executes NOPs forever: one fetch every 2 clocks, PC increments by 4.
- op 0x01 HALT: enter HALTED (no bus activity) until reset.
- op 0x02 LOADI: rd<=imm.
- op 0x03 LOAD word: rd<=mem[rs+imm].
- op 0x04 STORE word: mem[rs+imm]<=rd.
- op 0x05 LOADB: rd<=zero-extended byte.
- op 0x06 STOREB: store rd[7:0].
- op 0x08 JUMP: PC<=rs+imm.
- op 0x09 CALL: rd<=PC (already +4), PC<=rs+imm.
- op 0x0A BEQZ: if rs==0 then PC<=PC+imm. op 0x0B BNEZ: if rs!=0 then PC<=PC+imm. Offset is relative to the already-incremented PC.
- ALU register ops 0x10-0x17: rd<=rs OP rt. ALU immediate ops 0x18-0x1F: rd<=rs OP imm.
- OP order: ADD, SUB, AND, OR, XOR, SHL, SHR (logical), ASR. Shift amount is the low 5 bits of the second operand. All arithmetic is mod 2^32, no flags.
- MEMORY: address=EA[31:2], where EA=rs+imm is computed in EXECUTE and held.
  - Word access: strobes=1111.
  - Byte access: strobes=1000>>EA[1:0].
  - Load: read=1; at the edge rd<=data_in (word) or the selected lane zero-extended (byte).
  - Store: write=1; data_out=rd (word) or rd[7:0] replicated on all four lanes (byte).
  - Then go to FETCH.
- Faults detected in EXECUTE: undefined opcode; word load/store with EA[1:0]!=0; JUMP/CALL/taken-branch target with [1:0]!=0.
  - On a fault: go to FAULT with bus_error=1, no register or PC update and no bus cycle.
  - FAULT holds bus_error=1, read=write=0 until reset.
- Reset asserted in any state, including MEMORY mid-access, wins at the next edge. No partial register write occurs.
- Latency: non-memory instruction 2 clocks; load/store 3 clocks.

Test Plan:
- Reset, then data_in=0 constantly -> address sequence 0,4,8,... one step per 2 clocks, read=1 only in fetch cycles, strobes 1111, write=0, bus_error=0 forever.
- LOADI r1,0x1234; LOADI r2,0x100; STORE r1,[r2+4] -> write cycle at byte address 0x104, data_out=00001234, strobes=1111.
- LOADB r3,[r2+1] with data_in=AABBCCDD during the load -> strobes=0100, r3=000000BB. Verify by storing r3 and checking data_out.
- ALU: LOADI r1,-1; ADDI r1,r1,2 -> 1. SHR vs ASR on 0x80000000 by 4 -> 08000000 and F8000000.
- BNEZ taken with offset -8 refetches the address 4 bytes before the branch. CALL writes the return address; JUMP rs+imm lands at the target.
- LOAD word with EA=0x102 -> bus_error=1 from the next cycle, no further read/write. Reset clears it and refetches from 0.
